// File: rtl/ht_head_lookup.sv
// ht_head_lookup: hashes commands to buckets, reads the head table and
// emits one task per command in order, patching pointers from snooped writes.
// Ports: clk_i/rst_i; cmd_i/cmd_valid_i/cmd_ready_o in; ht_rd_* head-table
// read port; snoop_wr_* head-table write snoop; task_o/task_valid_o/task_ready_i out.

package hash_table;
  localparam int KEY_WIDTH        = 20;
  localparam int VALUE_WIDTH      = 16;
  localparam int BUCKET_WIDTH     = 8;
  localparam int TABLE_ADDR_WIDTH = 8;

  typedef enum logic [1:0] {
    OP_SEARCH = 2'd0,
    OP_INSERT = 2'd1,
    OP_DELETE = 2'd2,
    OP_NOP    = 2'd3
  } ht_opcode_t;

  typedef struct packed {
    ht_opcode_t             opcode;
    logic [KEY_WIDTH-1:0]   key;
    logic [VALUE_WIDTH-1:0] value;
  } ht_command_t;

  typedef struct packed {
    ht_command_t                 cmd;
    logic [BUCKET_WIDTH-1:0]     bucket;
    logic [TABLE_ADDR_WIDTH-1:0] head_ptr;
    logic                        head_ptr_val;
  } ht_pdata_t;
endpackage

module ht_head_lookup #(
  parameter int RAM_LATENCY  = 2,
  parameter int BUCKET_WIDTH = hash_table::BUCKET_WIDTH,
  parameter int A_WIDTH      = hash_table::TABLE_ADDR_WIDTH,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  hash_table::ht_command_t cmd_i,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  output logic [BUCKET_WIDTH-1:0] ht_rd_addr_o,
  output logic                    ht_rd_en_o,
  input  logic [A_WIDTH-1:0]      ht_rd_ptr_i,
  input  logic                    ht_rd_ptr_val_i,
  input  logic                    snoop_wr_en_i,
  input  logic [BUCKET_WIDTH-1:0] snoop_wr_addr_i,
  input  logic [A_WIDTH-1:0]      snoop_wr_ptr_i,
  input  logic                    snoop_wr_ptr_val_i,
  output hash_table::ht_pdata_t   task_o,
  output logic                    task_valid_o,
  input  logic                    task_ready_i
);

  localparam int KW  = hash_table::KEY_WIDTH;
  localparam int NSL = (KW + BUCKET_WIDTH - 1) / BUCKET_WIDTH;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(FIFO_DEPTH + RAM_LATENCY + 1) + 1;
  localparam int LL  = RAM_LATENCY - 1;

  typedef logic [BUCKET_WIDTH-1:0] bkt_t;
  typedef logic [A_WIDTH-1:0]      ptr_t;

  // hash: xor-fold of the key, top slice zero padded
  logic [NSL*BUCKET_WIDTH-1:0] key_pad;
  bkt_t                        hash_bkt;

  always_comb begin
    key_pad         = '0;
    key_pad[KW-1:0] = cmd_i.key;
    hash_bkt        = '0;
    for (int i = 0; i < NSL; i++) begin
      hash_bkt = hash_bkt ^ key_pad[i*BUCKET_WIDTH +: BUCKET_WIDTH];
    end
  end

  // credit: registered counts only, a pop frees credit next cycle
  logic [CW-1:0] infl_cnt;
  logic [CW-1:0] fifo_cnt;
  logic [CW:0]   used;
  logic          accept;

  assign used        = {1'b0, infl_cnt} + {1'b0, fifo_cnt};
  assign cmd_ready_o = !rst_i && (used < (CW+1)'(FIFO_DEPTH));
  assign accept      = cmd_valid_i && cmd_ready_o;
  assign ht_rd_en_o   = accept;
  assign ht_rd_addr_o = accept ? hash_bkt : '0;

  // shadow pipeline tracking reads in flight
  logic [LL:0]             sh_vld;
  logic [LL:0]             sh_fwd;
  logic [LL:0]             sh_pv;
  logic [LL:0]             sh_hit;
  hash_table::ht_command_t sh_cmd [RAM_LATENCY];
  bkt_t                    sh_bkt [RAM_LATENCY];
  ptr_t                    sh_ptr [RAM_LATENCY];
  logic                    acc_hit;

  always_comb begin
    sh_hit = '0;
    for (int i = 0; i < RAM_LATENCY; i++) begin
      sh_hit[i] = snoop_wr_en_i && (sh_bkt[i] == snoop_wr_addr_i);
    end
    acc_hit = snoop_wr_en_i && (hash_bkt == snoop_wr_addr_i);
  end

  // a snoop in the read cycle itself must override the read-old RAM data
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sh_vld <= '0;
      sh_fwd <= '0;
      sh_pv  <= '0;
      for (int i = 0; i < RAM_LATENCY; i++) begin
        sh_cmd[i] <= '0;
        sh_bkt[i] <= '0;
        sh_ptr[i] <= '0;
      end
    end else begin
      sh_vld[0] <= accept;
      sh_cmd[0] <= cmd_i;
      sh_bkt[0] <= hash_bkt;
      sh_fwd[0] <= acc_hit;
      sh_ptr[0] <= snoop_wr_ptr_i;
      sh_pv[0]  <= snoop_wr_ptr_val_i;
      for (int i = 1; i < RAM_LATENCY; i++) begin
        sh_vld[i] <= sh_vld[i-1];
        sh_cmd[i] <= sh_cmd[i-1];
        sh_bkt[i] <= sh_bkt[i-1];
        if (sh_hit[i-1]) begin
          sh_fwd[i] <= 1'b1;
          sh_ptr[i] <= snoop_wr_ptr_i;
          sh_pv[i]  <= snoop_wr_ptr_val_i;
        end else begin
          sh_fwd[i] <= sh_fwd[i-1];
          sh_ptr[i] <= sh_ptr[i-1];
          sh_pv[i]  <= sh_pv[i-1];
        end
      end
    end
  end

  // entry leaving the pipeline into the fifo tail
  logic                  push;
  logic                  pop;
  hash_table::ht_pdata_t push_data;

  assign push = sh_vld[LL];

  always_comb begin
    push_data.cmd    = sh_cmd[LL];
    push_data.bucket = sh_bkt[LL];
    if (sh_hit[LL]) begin
      push_data.head_ptr     = snoop_wr_ptr_i;
      push_data.head_ptr_val = snoop_wr_ptr_val_i;
    end else if (sh_fwd[LL]) begin
      push_data.head_ptr     = sh_ptr[LL];
      push_data.head_ptr_val = sh_pv[LL];
    end else begin
      push_data.head_ptr     = ht_rd_ptr_i;
      push_data.head_ptr_val = ht_rd_ptr_val_i;
    end
  end

  // first-word-fall-through output fifo
  hash_table::ht_pdata_t fifo_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;

  assign task_valid_o = (fifo_cnt != '0);
  assign task_o       = fifo_q[rd_ptr];
  assign pop          = task_valid_o && task_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      infl_cnt <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (snoop_wr_en_i && (fifo_q[i].bucket == snoop_wr_addr_i)) begin
          fifo_q[i].head_ptr     <= snoop_wr_ptr_i;
          fifo_q[i].head_ptr_val <= snoop_wr_ptr_val_i;
        end
      end
      if (push) begin
        fifo_q[wr_ptr] <= push_data;
      end
      wr_ptr   <= wr_ptr + PW'(push);
      rd_ptr   <= rd_ptr + PW'(pop);
      fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
      infl_cnt <= infl_cnt + CW'(accept) - CW'(push);
    end
  end

  // credit makes this unreachable
  always @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(push && (fifo_cnt == CW'(FIFO_DEPTH))));
    end
  end

endmodule
